ifetch_stage: RTL and testbench

- Instruction fetch stage, directly upstream of the instruction memory and the decode stage.
- Owns the program counter and drives it as the byte address into the combinational-read instruction memory.
- Captures the returned 32-bit word, with its PC, into the IF/ID pipeline register.
- Handles decode stalls, branch/jump redirects and a halt condition, so the core stops fetching cleanly at end of program.

---
 rtl/riscv_pkg.sv | 27 ++
 rtl/ifetch_stage.sv | 112 +++++++++++
 tb/tb_ifetch_stage.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Brief    : Shared fetch-stage types and instruction constants.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam int          XLEN        = 64;
    localparam int          ILEN        = 32;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    localparam logic [31:0] ECALL_INSTR = 32'h0000_0073;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } if_id_t;

endpackage
`default_nettype wire

// File: rtl/ifetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_stage
// Brief    : PC owner and IF/ID register with stall, redirect and halt.
// Revision : 1.0 - initial release
// ============================================================================
module ifetch_stage
    import riscv_pkg::*;
#(
    parameter logic [63:0]     RESET_PC   = 64'h0,
    parameter int              BITS       = 32,
    parameter logic [BITS-1:0] HALT_INSTR = riscv_pkg::ECALL_INSTR,
    parameter logic [BITS-1:0] NOP_INSTR  = riscv_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            reset,
    output logic [63:0]     imem_addr,
    input  logic [BITS-1:0] imem_instr,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [63:0]     redirect_pc,
    output logic            id_valid,
    output logic [63:0]     id_pc,
    output logic [BITS-1:0] id_instr,
    output logic            halted,
    output logic [31:0]     fetch_count
);

    fetch_state_t state_q, state_d;
    logic [63:0]  pc_q, pc_d;
    if_id_t       if_id_q, if_id_d;
    logic [31:0]  count_q, count_d;
    logic         w_is_halt;

    assign w_is_halt = (imem_instr == HALT_INSTR);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (!redirect_valid && !stall && w_is_halt) state_d = HALT;
            HALT:    if (redirect_valid) state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    always_comb begin
        halted = (state_q == HALT);
    end

    // Redirect beats stall: the flushed slot must become a bubble even while decode is stalled.
    always_comb begin
        pc_d    = pc_q;
        if_id_d = if_id_q;
        count_d = count_q;
        if (redirect_valid) begin
            pc_d = {redirect_pc[63:2], 2'b00};
            if (state_q != BOOT) begin
                if_id_d.valid = 1'b0;
                if_id_d.instr = NOP_INSTR;
            end
        end else if (!stall) begin
            case (state_q)
                RUN: begin
                    if_id_d.valid = 1'b1;
                    if_id_d.pc    = pc_q;
                    if_id_d.instr = imem_instr;
                    if (count_q != 32'hFFFF_FFFF) begin
                        count_d = count_q + 32'd1;
                    end
                    if (!w_is_halt) begin
                        pc_d = pc_q + 64'd4;
                    end
                end
                HALT: begin
                    if_id_d.valid = 1'b0;
                    if_id_d.instr = NOP_INSTR;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            if_id_q <= '{valid: 1'b0, pc: 64'h0, instr: NOP_INSTR};
            count_q <= 32'h0;
        end else begin
            pc_q    <= pc_d;
            if_id_q <= if_id_d;
            count_q <= count_d;
        end
    end

    assign imem_addr   = pc_q;
    assign id_valid    = if_id_q.valid;
    assign id_pc       = if_id_q.pc;
    assign id_instr    = if_id_q.instr;
    assign fetch_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_ifetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifetch_stage
// Brief    : Directed plus randomized self-checking bench for ifetch_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifetch_stage;

    localparam logic [31:0] HALT_W = 32'h0000_0073;
    localparam logic [31:0] NOP_W  = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'h0;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        id_valid;
    logic [63:0] id_pc;
    logic [31:0] id_instr;
    logic        halted;
    logic [31:0] fetch_count;

    logic [31:0] mem [256];

    int total = 0;
    int bad   = 0;

    // Reference state, expressed directly from the fetch rules.
    logic [63:0] m_pc, m_idpc;
    logic [31:0] m_instr, m_cnt;
    bit          m_boot, m_halt, m_valid;

    ifetch_stage #(
        .RESET_PC   (64'h0),
        .BITS       (32),
        .HALT_INSTR (HALT_W),
        .NOP_INSTR  (NOP_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_instr       (id_instr),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    assign imem_instr = mem[imem_addr[9:2]];

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit s, input bit rv, input logic [63:0] rpc);
        logic [31:0] w;
        if (r) begin
            m_pc = 64'h0; m_boot = 1; m_halt = 0; m_valid = 0;
            m_idpc = 64'h0; m_instr = NOP_W; m_cnt = 32'h0;
        end else if (m_boot) begin
            m_boot = 0;
            if (rv) m_pc = rpc & ~64'h3;
        end else if (rv) begin
            m_pc = rpc & ~64'h3; m_valid = 0; m_instr = NOP_W; m_halt = 0;
        end else if (s) begin
        end else if (m_halt) begin
            m_valid = 0; m_instr = NOP_W;
        end else begin
            w = mem[m_pc[9:2]];
            m_valid = 1; m_idpc = m_pc; m_instr = w;
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            if (w == HALT_W) m_halt = 1;
            else             m_pc = m_pc + 64'd4;
        end
    endtask

    task automatic step(input bit r, input bit s, input bit rv, input logic [63:0] rpc);
        @(negedge clk);
        reset = r; stall = s; redirect_valid = rv; redirect_pc = rpc;
        @(posedge clk);
        model_edge(r, s, rv, rpc);
        #1;
        chk("imem_addr",   imem_addr,   m_pc);
        chk("id_valid",    {63'h0, id_valid}, {63'h0, m_valid});
        chk("id_pc",       id_pc,       m_idpc);
        chk("id_instr",    {32'h0, id_instr},    {32'h0, m_instr});
        chk("halted",      {63'h0, halted},      {63'h0, m_halt});
        chk("fetch_count", {32'h0, fetch_count}, {32'h0, m_cnt});
    endtask

    initial begin
        logic [31:0] w;
        logic [63:0] t;
        for (int i = 0; i < 256; i++) begin
            w = $urandom;
            if (i >= 80 && ($urandom % 10) == 0) w = HALT_W;
            else if (w == HALT_W) w = w ^ 32'h1;
            mem[i] = w;
        end
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h00A0_0113;
        mem[2] = HALT_W;
        mem[255] = 32'h0010_0193;

        // Reset and boot.
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("reset_instr", {32'h0, id_instr}, {32'h0, NOP_W});
        step(0, 0, 0, 0);
        chk("boot_no_capture", {63'h0, id_valid}, 64'h0);

        // Straight-line fetch.
        step(0, 0, 0, 0);
        chk("first_word", {32'h0, id_instr}, 64'h0050_0093);
        step(0, 0, 0, 0);
        chk("second_pc", id_pc, 64'h4);
        chk("count_two", {32'h0, fetch_count}, 64'd2);

        // Stall for three cycles, then release onto the halt word.
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0);
            chk("stall_addr", imem_addr, 64'h8);
            chk("stall_idpc", id_pc, 64'h4);
        end
        step(0, 0, 0, 0);
        chk("halt_delivered", {32'h0, id_instr}, {32'h0, HALT_W});
        step(0, 0, 0, 0);
        chk("halt_bubble", {63'h0, id_valid}, 64'h0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        chk("halt_addr", imem_addr, 64'h8);
        chk("halt_flag", {63'h0, halted}, 64'h1);

        // Resume, then redirect with low bits set.
        step(0, 0, 1, 64'h0);
        chk("resume_halted", {63'h0, halted}, 64'h0);
        step(0, 0, 1, 64'h10);
        step(0, 0, 1, 64'h103);
        chk("redir_addr", imem_addr, 64'h100);
        chk("redir_bubble", {32'h0, id_instr}, {32'h0, NOP_W});
        step(0, 0, 0, 0);
        chk("redir_idpc", id_pc, 64'h100);

        // Redirect and stall together.
        step(0, 1, 1, 64'h20);
        chk("redir_stall_valid", {63'h0, id_valid}, 64'h0);
        chk("redir_stall_pc", imem_addr, 64'h20);

        // PC wraps past the top of the address space.
        step(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
        step(0, 0, 0, 0);
        chk("wrap_addr", imem_addr, 64'h0);

        // Reset mid-run with a valid instruction in IF/ID.
        step(0, 0, 1, 64'h40);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("midrst_valid", {63'h0, id_valid}, 64'h0);
        chk("midrst_count", {32'h0, fetch_count}, 64'h0);
        step(0, 0, 1, 64'h30);
        chk("boot_redirect", imem_addr, 64'h30);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            t = {54'h0, 10'($urandom)};
            if (($urandom % 16) == 0) t[63:40] = 24'($urandom);
            step(($urandom % 64) == 0, ($urandom % 4) == 0, ($urandom % 8) == 0, t);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
